// File: rtl/sixbitlog.sv
// sixbitlog: iterative integer logarithm, largest e with ain**e <= vin, one multiply per clock.
module sixbitlog #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] vin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] log,
  output logic             exact,
  output logic             err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_a, r_v, r_acc, r_e, r_log;
  logic               r_done, r_exact, r_err;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_bad, w_over;
  // Full-width product: acc <= v < 2**WIDTH, so the step can never wrap.
  assign w_prod = (2*WIDTH)'(r_acc) * (2*WIDTH)'(r_a);
  assign w_bad  = (r_a < WIDTH'(2)) || (r_v == '0);
  assign w_over = w_prod > (2*WIDTH)'(r_v);
  assign busy   = (r_state == RUN);
  assign done   = r_done;
  assign log    = r_log;
  assign exact  = r_exact;
  assign err    = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_v     <= '0;
      r_acc   <= WIDTH'(1);
      r_e     <= '0;
      r_log   <= '0;
      r_done  <= 1'b0;
      r_exact <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_a     <= ain;
          r_v     <= vin;
          r_acc   <= WIDTH'(1);
          r_e     <= '0;
          r_state <= RUN;
        end
      end else if (w_bad) begin
        r_log   <= '0;
        r_exact <= 1'b0;
        r_err   <= 1'b1;
        r_done  <= 1'b1;
        r_state <= IDLE;
      end else if (w_over) begin
        r_log   <= r_e;
        r_exact <= (r_acc == r_v);
        r_err   <= 1'b0;
        r_done  <= 1'b1;
        r_state <= IDLE;
      end else begin
        r_acc <= w_prod[WIDTH-1:0];
        r_e   <= r_e + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sixbitlog.sv
// tb_sixbitlog: directed vector table, hand-written corner sequences and an exhaustive sweep for sixbitlog.
module tb_sixbitlog;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [5:0] ain, vin;
  logic       busy, done, exact, err;
  logic [5:0] log;
  int         checks = 0;
  int         errors = 0;

  sixbitlog #(.WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ain(ain), .vin(vin),
    .busy(busy), .done(done), .log(log), .exact(exact), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, v, elog, eexact, eerr, elat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge of the done cycle (or after a 20-cycle bound).
  task automatic do_op(input int a, input int v, output int lat, output int busy_bad);
    ain = 6'(a);
    vin = 6'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_bad = 0;
    do begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    if (busy) busy_bad++;
  endtask

  function automatic void model(input int a, input int v, output int ml, output int mx, output int me);
    int p;
    ml = 0; mx = 0; me = 0;
    if (a < 2 || v == 0) me = 1;
    else begin
      p = 1;
      while (p * a <= v) begin p = p * a; ml++; end
      mx = (p == v) ? 1 : 0;
    end
  endfunction

  vec_t vecs[11];

  initial begin
    int lat, bb, ml, mx, me, seen;
    vecs[0]  = '{2, 63, 5, 0, 0, 6};
    vecs[1]  = '{3, 27, 3, 1, 0, 4};
    vecs[2]  = '{63, 62, 0, 0, 0, 1};
    vecs[3]  = '{1, 5, 0, 0, 1, 1};
    vecs[4]  = '{0, 9, 0, 0, 1, 1};
    vecs[5]  = '{4, 0, 0, 0, 1, 1};
    vecs[6]  = '{5, 25, 2, 1, 0, 3};
    vecs[7]  = '{7, 48, 1, 0, 0, 2};
    vecs[8]  = '{2, 1, 0, 1, 0, 1};
    vecs[9]  = '{63, 63, 1, 1, 0, 2};
    vecs[10] = '{2, 2, 1, 1, 0, 2};
    rst_n = 1'b0; start = 1'b0; ain = '0; vin = '0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset log", log, 0);
    chk("reset exact", exact, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Consecutive entries also exercise start during the done cycle.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].v, lat, bb);
      chk($sformatf("vec%0d lat", i), lat, vecs[i].elat);
      chk($sformatf("vec%0d log", i), log, vecs[i].elog);
      chk($sformatf("vec%0d exact", i), exact, vecs[i].eexact);
      chk($sformatf("vec%0d err", i), err, vecs[i].eerr);
      chk($sformatf("vec%0d busy", i), bb, 0);
    end
    @(negedge clk);
    chk("done one cycle", done, 0);
    chk("idle after done", busy, 0);
    ain = 6'd2; vin = 6'd32; start = 1'b1;
    @(negedge clk);
    ain = 6'd3; vin = 6'd5; start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      start = ~start;
      ain = ain + 6'd7;
      vin = vin + 6'd11;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("noisy lat", lat, 6);
    chk("noisy log", log, 5);
    chk("noisy exact", exact, 1);
    chk("noisy err", err, 0);
    @(negedge clk);
    chk("noisy no restart", busy, 0);
    do_op(3, 27, lat, bb);
    do_op(5, 25, lat, bb);
    chk("b2b lat", lat, 3);
    chk("b2b log", log, 2);
    chk("b2b exact", exact, 1);
    @(negedge clk);
    ain = 6'd2; vin = 6'd63; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst log", log, 0);
    chk("midrst exact", exact, 0);
    chk("midrst err", err, 0);
    chk("midrst done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst no done", seen, 0);
    do_op(2, 63, lat, bb);
    chk("post rst lat", lat, 6);
    chk("post rst log", log, 5);
    chk("post rst exact", exact, 0);
    for (int a = 0; a < 64; a++) begin
      for (int v = 0; v < 64; v++) begin
        model(a, v, ml, mx, me);
        do_op(a, v, lat, bb);
        chk($sformatf("sw a=%0d v=%0d log", a, v), log, ml);
        chk($sformatf("sw a=%0d v=%0d exact", a, v), exact, mx);
        chk($sformatf("sw a=%0d v=%0d err", a, v), err, me);
        chk($sformatf("sw a=%0d v=%0d lat", a, v), lat, me ? 1 : ml + 1);
        chk($sformatf("sw a=%0d v=%0d busy", a, v), bb, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
